// File: rtl/clint_seq_pkg.sv
// Shared definitions for the clint_seq interrupt sequencer: CSR addresses,
// instruction encodings, FSM states and the mstatus rewrite helpers.
package clint_seq_pkg;

  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;
  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic HoldEnable = 1'b1;
  localparam logic RstEnable  = 1'b0;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_IRQ0   = 32'h8000_0010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEPC,
    S_MCAUSE,
    S_MSTATUS,
    S_MRET,
    S_ASSERT
  } state_e;

  // Trap entry: MPIE <= MIE, MIE <= 0.
  function automatic logic [31:0] mstatus_trap(input logic [31:0] s);
    return {s[31:8], s[3], s[6:4], 1'b0, s[2:0]};
  endfunction

  // Trap return: MIE <= MPIE, MPIE <= 1.
  function automatic logic [31:0] mstatus_mret(input logic [31:0] s);
    return {s[31:8], 1'b1, s[6:4], s[7], s[2:0]};
  endfunction

endpackage

// File: rtl/clint_seq_irq_prio_enc.sv
// Lowest-index-wins priority encoder over the external interrupt lines.
module irq_prio_enc #(
  parameter int IRQ_NUM = 8
) (
  input  logic [IRQ_NUM-1:0] i_flag,
  output logic [3:0]         o_idx,
  output logic               o_vld
);

  always_comb begin
    o_idx = 4'd0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (i_flag[i]) o_idx = 4'(i);
    end
  end

  assign o_vld = |i_flag;

endmodule

// File: rtl/clint_seq.sv
// Core-local trap/interrupt sequencer: holds the pipeline, writes mepc/mcause/
// mstatus, then redirects. Define CLINT_VECTORED_EN for vectored async targets.
module clint_seq
  import clint_seq_pkg::*;
#(
  parameter int IRQ_NUM = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IRQ_NUM-1:0] int_flag_i,
  input  logic [31:0]        inst_i,
  input  logic [31:0]        inst_addr_i,
  input  logic               jump_flag_i,
  input  logic [31:0]        jump_addr_i,
  input  logic               div_started_i,
  input  logic [31:0]        csr_mtvec_i,
  input  logic [31:0]        csr_mepc_i,
  input  logic [31:0]        csr_mstatus_i,
  input  logic               global_int_en_i,
  output logic               hold_flag_o,
  output logic               we_o,
  output logic [31:0]        waddr_o,
  output logic [31:0]        data_o,
  output logic               int_assert_o,
  output logic [31:0]        int_addr_o
);

  state_e      r_state;
  logic [31:0] r_cause;
  logic        r_async;
  logic        r_we;
  logic [31:0] r_waddr;
  logic [31:0] r_data;
  logic        r_int_assert;
  logic [31:0] r_int_addr;

  logic [3:0]  w_irq_idx;
  logic        w_irq_vld;
  logic        w_idle;
  logic        w_sync;
  logic        w_mret;
  logic        w_async;
  logic [31:0] w_mtvec_base;
  logic [31:0] w_trap_addr;

  irq_prio_enc #(.IRQ_NUM(IRQ_NUM)) u_prio (
    .i_flag (int_flag_i),
    .o_idx  (w_irq_idx),
    .o_vld  (w_irq_vld)
  );

  assign w_idle  = (r_state == S_IDLE);
  assign w_sync  = w_idle && ((inst_i == INST_ECALL) || (inst_i == INST_EBREAK));
  assign w_mret  = w_idle && (inst_i == INST_MRET);
  assign w_async = w_idle && w_irq_vld && global_int_en_i && !div_started_i;

  assign w_mtvec_base = {csr_mtvec_i[31:2], 2'b00};

`ifdef CLINT_VECTORED_EN
  logic w_unused_cause_hi;
  assign w_unused_cause_hi = ^r_cause[31:30];
  assign w_trap_addr = (r_async && (csr_mtvec_i[1:0] == 2'b01))
                     ? w_mtvec_base + {r_cause[29:0], 2'b00}
                     : w_mtvec_base;
`else
  logic w_unused_mode;
  assign w_unused_mode = ^{csr_mtvec_i[1:0], r_async};
  assign w_trap_addr = w_mtvec_base;
`endif

  // Detection raises hold in the same cycle; afterwards the state keeps it up.
  assign hold_flag_o  = !w_idle || w_sync || w_mret || w_async;
  assign we_o         = r_we;
  assign waddr_o      = r_waddr;
  assign data_o       = r_data;
  assign int_assert_o = r_int_assert;
  assign int_addr_o   = r_int_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_state      <= S_IDLE;
      r_cause      <= '0;
      r_async      <= 1'b0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_data       <= '0;
      r_int_assert <= 1'b0;
      r_int_addr   <= '0;
    end else begin
      // Outputs are pulses tied to the state being entered; default to idle.
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_data       <= '0;
      r_int_assert <= 1'b0;
      r_int_addr   <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_sync) begin
            r_state <= S_MEPC;
            r_cause <= (inst_i == INST_EBREAK) ? CAUSE_EBREAK : CAUSE_ECALL;
            r_async <= 1'b0;
            r_we    <= 1'b1;
            r_waddr <= CSR_MEPC;
            r_data  <= inst_addr_i;
          end else if (w_mret) begin
            r_state <= S_MRET;
            r_we    <= 1'b1;
            r_waddr <= CSR_MSTATUS;
            r_data  <= mstatus_mret(csr_mstatus_i);
          end else if (w_async) begin
            r_state <= S_MEPC;
            r_cause <= CAUSE_IRQ0 + {28'd0, w_irq_idx};
            r_async <= 1'b1;
            r_we    <= 1'b1;
            r_waddr <= CSR_MEPC;
            r_data  <= jump_flag_i ? jump_addr_i : inst_addr_i;
          end
        end
        S_MEPC: begin
          r_state <= S_MCAUSE;
          r_we    <= 1'b1;
          r_waddr <= CSR_MCAUSE;
          r_data  <= r_cause;
        end
        S_MCAUSE: begin
          r_state <= S_MSTATUS;
          r_we    <= 1'b1;
          r_waddr <= CSR_MSTATUS;
          r_data  <= mstatus_trap(csr_mstatus_i);
        end
        S_MSTATUS: begin
          r_state      <= S_ASSERT;
          r_int_assert <= 1'b1;
          r_int_addr   <= w_trap_addr;
        end
        S_MRET: begin
          r_state      <= S_ASSERT;
          r_int_assert <= 1'b1;
          r_int_addr   <= csr_mepc_i;
        end
        S_ASSERT: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clint_seq.sv
// Directed bench for clint_seq: trap, interrupt, mret, divide deferral, reset.
module tb_clint_seq;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  int_flag_i = '0;
  logic [31:0] inst_i = NOP;
  logic [31:0] inst_addr_i = '0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        div_started_i = 1'b0;
  logic [31:0] csr_mtvec_i = 32'h200;
  logic [31:0] csr_mepc_i = '0;
  logic [31:0] csr_mstatus_i = 32'h8;
  logic        global_int_en_i = 1'b0;
  logic        hold_flag_o;
  logic        we_o;
  logic [31:0] waddr_o;
  logic [31:0] data_o;
  logic        int_assert_o;
  logic [31:0] int_addr_o;

  int checks = 0;
  int errors = 0;

  clint_seq #(.IRQ_NUM(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .int_flag_i      (int_flag_i),
    .inst_i          (inst_i),
    .inst_addr_i     (inst_addr_i),
    .jump_flag_i     (jump_flag_i),
    .jump_addr_i     (jump_addr_i),
    .div_started_i   (div_started_i),
    .csr_mtvec_i     (csr_mtvec_i),
    .csr_mepc_i      (csr_mepc_i),
    .csr_mstatus_i   (csr_mstatus_i),
    .global_int_en_i (global_int_en_i),
    .hold_flag_o     (hold_flag_o),
    .we_o            (we_o),
    .waddr_o         (waddr_o),
    .data_o          (data_o),
    .int_assert_o    (int_assert_o),
    .int_addr_o      (int_addr_o)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic eh, input logic ew,
                     input logic [31:0] ea, input logic [31:0] ed,
                     input logic ei, input logic [31:0] eia);
    logic [98:0] obs;
    logic [98:0] exp;
    #1;
    obs = {hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o};
    exp = {eh, ew, ea, ed, ei, eia};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed hold=%b we=%b waddr=%h data=%h assert=%b addr=%h, expected hold=%b we=%b waddr=%h data=%h assert=%b addr=%h",
             tag, hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o,
             eh, ew, ea, ed, ei, eia);
    end
  endtask

  initial begin
    logic [31:0] vec_addr;
    #1 rst = 1'b0;
    chk("reset", 0, 0, 0, 0, 0, 0);
    cyc();
    chk("reset_hold", 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;

    // ecall at 0x100
    cyc();
    inst_i = ECALL; inst_addr_i = 32'h100; csr_mtvec_i = 32'h200;
    csr_mstatus_i = 32'h8; global_int_en_i = 1'b1;
    chk("ecall_c0", 1, 0, 0, 0, 0, 0);
    cyc(); inst_i = NOP;
    chk("ecall_mepc", 1, 1, 32'h341, 32'h100, 0, 0);
    cyc();
    chk("ecall_mcause", 1, 1, 32'h342, 32'd11, 0, 0);
    cyc();
    chk("ecall_mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
    global_int_en_i = 1'b0; csr_mstatus_i = 32'h80;
    cyc();
    chk("ecall_assert", 1, 0, 0, 0, 1, 32'h200);
    cyc();
    chk("ecall_done", 0, 0, 0, 0, 0, 0);

    // async irq 2 while ex takes a jump
    cyc();
    csr_mstatus_i = 32'h8; global_int_en_i = 1'b1; int_flag_i = 8'b0000_0100;
    jump_flag_i = 1'b1; jump_addr_i = 32'h340; inst_addr_i = 32'h150;
    chk("irq_c0", 1, 0, 0, 0, 0, 0);
    cyc(); jump_flag_i = 1'b0;
    chk("irq_mepc", 1, 1, 32'h341, 32'h340, 0, 0);
    cyc();
    chk("irq_mcause", 1, 1, 32'h342, 32'h8000_0012, 0, 0);
    cyc();
    chk("irq_mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
    global_int_en_i = 1'b0; csr_mstatus_i = 32'h80;
    cyc();
    chk("irq_assert", 1, 0, 0, 0, 1, 32'h200);
    cyc();
    chk("irq_not_retaken", 0, 0, 0, 0, 0, 0);
    int_flag_i = '0;

    // mret
    cyc();
    inst_i = MRET; csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104;
    chk("mret_c0", 1, 0, 0, 0, 0, 0);
    cyc(); inst_i = NOP;
    chk("mret_mstatus", 1, 1, 32'h300, 32'h88, 0, 0);
    cyc();
    chk("mret_assert", 1, 0, 0, 0, 1, 32'h104);
    cyc();
    chk("mret_done", 0, 0, 0, 0, 0, 0);

    // interrupt deferred by divide
    cyc();
    csr_mstatus_i = 32'h8; global_int_en_i = 1'b1; int_flag_i = 8'b0000_0001;
    div_started_i = 1'b1; inst_addr_i = 32'h180;
    chk("div_hold_0", 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 5; i++) begin
      cyc();
      chk("div_hold_n", 0, 0, 0, 0, 0, 0);
    end
    cyc(); div_started_i = 1'b0;
    chk("div_fall_c0", 1, 0, 0, 0, 0, 0);
    cyc();
    chk("div_mepc", 1, 1, 32'h341, 32'h180, 0, 0);
    cyc();
    chk("div_mcause", 1, 1, 32'h342, 32'h8000_0010, 0, 0);
    cyc(); global_int_en_i = 1'b0;
    cyc();
    chk("div_assert", 1, 0, 0, 0, 1, 32'h200);
    cyc(); int_flag_i = '0;
    chk("div_done", 0, 0, 0, 0, 0, 0);

    // ecall and interrupt together: ecall wins, irq not retaken
    cyc();
    inst_i = ECALL; inst_addr_i = 32'h120; int_flag_i = 8'b0000_0010;
    csr_mstatus_i = 32'h8; global_int_en_i = 1'b1;
    chk("both_c0", 1, 0, 0, 0, 0, 0);
    cyc(); inst_i = NOP;
    chk("both_mepc", 1, 1, 32'h341, 32'h120, 0, 0);
    cyc();
    chk("both_mcause", 1, 1, 32'h342, 32'd11, 0, 0);
    cyc(); global_int_en_i = 1'b0;
    cyc();
    chk("both_assert", 1, 0, 0, 0, 1, 32'h200);
    cyc();
    chk("both_not_retaken", 0, 0, 0, 0, 0, 0);
    int_flag_i = '0;

    // ebreak cause
    cyc();
    inst_i = EBREAK; inst_addr_i = 32'h130; csr_mstatus_i = 32'h0;
    cyc(); inst_i = NOP;
    cyc();
    chk("ebreak_mcause", 1, 1, 32'h342, 32'd3, 0, 0);
    cyc();
    chk("ebreak_mstatus", 1, 1, 32'h300, 32'h0, 0, 0);
    cyc(); cyc();
    chk("ebreak_done", 0, 0, 0, 0, 0, 0);

    // reset during MCAUSE
    cyc();
    inst_i = ECALL; inst_addr_i = 32'h100; csr_mstatus_i = 32'h8;
    cyc(); inst_i = NOP;
    cyc();
    chk("rst_pre_mcause", 1, 1, 32'h342, 32'd11, 0, 0);
    rst = 1'b0;
    chk("rst_mid_seq", 0, 0, 0, 0, 0, 0);
    cyc();
    #1 rst = 1'b1;
    cyc();
    chk("rst_idle_after", 0, 0, 0, 0, 0, 0);

    // async trap with mode bits 01 in mtvec
`ifdef CLINT_VECTORED_EN
    vec_addr = 32'h240;
`else
    vec_addr = 32'h200;
`endif
    cyc();
    csr_mtvec_i = 32'h201; csr_mstatus_i = 32'h8; global_int_en_i = 1'b1;
    int_flag_i = 8'b0000_0001; inst_addr_i = 32'h190;
    cyc(); int_flag_i = '0;
    cyc(); cyc(); global_int_en_i = 1'b0;
    cyc();
    chk("vec_assert", 1, 0, 0, 0, 1, vec_addr);
    cyc();
    chk("vec_done", 0, 0, 0, 0, 0, 0);

    // sync trap with mode bits 01 always goes to the base
    cyc();
    inst_i = ECALL; inst_addr_i = 32'h1a0;
    cyc(); inst_i = NOP;
    cyc(); cyc(); cyc();
    chk("vec_sync_base", 1, 0, 0, 0, 1, 32'h200);

    cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
